// File: rtl/multdiv_64.sv
// rtl/multdiv_64.sv - iterative 64-bit signed multiply/divide unit
// Define MULTDIV_BOOTH_EN for a radix-4 Booth multiply (32 iterations); divide always takes 64.
module multdiv_64 (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] data_operandA,
  input  logic [63:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [63:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

`ifdef MULTDIV_BOOTH_EN
  localparam logic [6:0] MUL_LAST = 7'd31;
`else
  localparam logic [6:0] MUL_LAST = 7'd63;
`endif
  localparam logic [6:0] DIV_LAST = 7'd63;
  localparam logic [63:0] MIN_INT = 64'h8000_0000_0000_0000;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q;
  // hi/lo: product halves for multiply, partial remainder / shifting dividend for divide
  logic [63:0] hi_q, lo_q, mcand_q;
  logic        neg_q, ovf_q;
  logic        start_mul, start_div;

  logic [63:0] abs_a, abs_b;
  logic [63:0] mul_hi, mul_lo;
  logic        mul_ovf;
  logic [64:0] div_diff;
  logic [63:0] div_rem, div_quo, quo_final;

  assign abs_a = data_operandA[63] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[63] ? -data_operandB : data_operandB;

  always_comb begin
    state_d   = state_q;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_MULT) begin
          start_mul = 1'b1;
          state_d   = MUL;
        end else if (ctrl_DIV) begin
          start_div = 1'b1;
          state_d   = (data_operandB == 64'd0) ? DONE : DIV;
        end
      end
      MUL:     if (cnt_q == MUL_LAST) state_d = DONE;
      DIV:     if (cnt_q == DIV_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MULTDIV_BOOTH_EN
  logic        booth_q;
  logic [65:0] booth_add, booth_sum;
  always_comb begin
    case ({lo_q[1:0], booth_q})
      3'b001, 3'b010: booth_add = {{2{mcand_q[63]}}, mcand_q};
      3'b011:         booth_add = {mcand_q[63], mcand_q, 1'b0};
      3'b100:         booth_add = -{mcand_q[63], mcand_q, 1'b0};
      3'b101, 3'b110: booth_add = -{{2{mcand_q[63]}}, mcand_q};
      default:        booth_add = '0;
    endcase
    booth_sum = {{2{hi_q[63]}}, hi_q} + booth_add;
    mul_hi    = booth_sum[65:2];
    mul_lo    = {booth_sum[1:0], lo_q[63:2]};
  end
`else
  logic [64:0] r2_add, r2_sum;
  always_comb begin
    // multiplier bit 63 carries weight -2^63, so the final step subtracts
    r2_add = !lo_q[0] ? 65'd0 :
             (cnt_q == MUL_LAST) ? -{mcand_q[63], mcand_q} : {mcand_q[63], mcand_q};
    r2_sum = {hi_q[63], hi_q} + r2_add;
    mul_hi = r2_sum[64:1];
    mul_lo = {r2_sum[0], lo_q[63:1]};
  end
`endif

  assign mul_ovf = ~((&{mul_hi, mul_lo[63]}) | ~(|{mul_hi, mul_lo[63]}));

  always_comb begin
    div_diff  = {hi_q, lo_q[63]} - {1'b0, mcand_q};
    div_quo   = {lo_q[62:0], ~div_diff[64]};
    div_rem   = div_diff[64] ? {hi_q[62:0], lo_q[63]} : div_diff[63:0];
    quo_final = neg_q ? -div_quo : div_quo;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 7'd0;
      hi_q           <= 64'd0;
      lo_q           <= 64'd0;
      mcand_q        <= 64'd0;
      neg_q          <= 1'b0;
      ovf_q          <= 1'b0;
      data_result    <= 64'd0;
      data_exception <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
      booth_q        <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + 7'd1;
      if (start_mul) begin
        cnt_q   <= 7'd0;
        mcand_q <= data_operandA;
        hi_q    <= 64'd0;
        lo_q    <= data_operandB;
`ifdef MULTDIV_BOOTH_EN
        booth_q <= 1'b0;
`endif
      end else if (start_div) begin
        cnt_q   <= 7'd0;
        mcand_q <= abs_b;
        hi_q    <= 64'd0;
        lo_q    <= abs_a;
        neg_q   <= data_operandA[63] ^ data_operandB[63];
        ovf_q   <= (data_operandA == MIN_INT) && (data_operandB == '1);
        if (data_operandB == 64'd0) begin
          data_result    <= 64'd0;
          data_exception <= 1'b1;
        end
      end else if (state_q == MUL) begin
        hi_q <= mul_hi;
        lo_q <= mul_lo;
`ifdef MULTDIV_BOOTH_EN
        booth_q <= lo_q[1];
`endif
        if (cnt_q == MUL_LAST) begin
          data_result    <= mul_lo;
          data_exception <= mul_ovf;
        end
      end else if (state_q == DIV) begin
        hi_q <= div_rem;
        lo_q <= div_quo;
        if (cnt_q == DIV_LAST) begin
          data_result    <= quo_final;
          data_exception <= ovf_q;
        end
      end
    end
  end

  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_multdiv_64.sv
// tb/tb_multdiv_64.sv - directed self-checking bench for multdiv_64
module tb_multdiv_64;
`ifdef MULTDIV_BOOTH_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 65;
`endif
  localparam int DIV_LAT = 65;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] data_operandA = 64'd0;
  logic [63:0] data_operandB = 64'd0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [63:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  multdiv_64 dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the start in cycle 0; return at the sampling point of cycle 1 with operands scrambled.
  task automatic start_op(input logic m, input logic d, input logic [63:0] a, input logic [63:0] b);
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = {$urandom, $urandom};
    data_operandB = {$urandom, $urandom};
  endtask

  task automatic run(input string tag, input logic m, input logic d,
                     input logic [63:0] a, input logic [63:0] b, input int exp_cyc,
                     input logic [63:0] exp_res, input logic exp_exc, input int pulse_at);
    int cyc;
    int nrdy;
    logic busy_ok;
    logic [63:0] res;
    logic exc;
    cyc = -1;
    nrdy = 0;
    busy_ok = 1'b1;
    res = 64'd0;
    exc = 1'b0;
    start_op(m, d, a, b);
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        nrdy++;
        if (cyc < 0) begin
          cyc = k;
          res = data_result;
          exc = data_exception;
        end
      end
      if (busy !== ((cyc < 0) || (k == cyc))) busy_ok = 1'b0;
      ctrl_DIV = (k == pulse_at);
    end
    ctrl_DIV = 1'b0;
    check({tag, ".rdy_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, ".result"}, res, exp_res);
    check({tag, ".exception"}, {63'd0, exc}, {63'd0, exp_exc});
    check({tag, ".rdy_count"}, 64'(nrdy), 64'd1);
    check({tag, ".busy"}, {63'd0, busy_ok}, 64'd1);
    check({tag, ".hold"}, data_result, exp_res);
  endtask

  initial begin
    int nrdy;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset.result", data_result, 64'd0);
    check("reset.exception", {63'd0, data_exception}, 64'd0);
    check("reset.rdy", {63'd0, data_resultRDY}, 64'd0);
    check("reset.busy", {63'd0, busy}, 64'd0);

    run("mul_7_m3", 1, 0, 64'd7, -64'sd3, MUL_LAT, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0);
    run("mul_ovf", 1, 0, 64'h4000_0000_0000_0000, 64'd2, MUL_LAT, 64'h8000_0000_0000_0000, 1, 0);
    run("mul_m1_m1", 1, 0, '1, '1, MUL_LAT, 64'd1, 0, 0);
    run("mul_2p64", 1, 0, 64'h1_0000_0000, 64'h1_0000_0000, MUL_LAT, 64'd0, 1, 0);
    run("div_m100_7", 0, 1, -64'sd100, 64'd7, DIV_LAT, 64'hFFFF_FFFF_FFFF_FFF2, 0, 0);
    run("div_by_zero", 0, 1, 64'd100, 64'd0, 1, 64'd0, 1, 0);
    run("div_min_m1", 0, 1, 64'h8000_0000_0000_0000, '1, DIV_LAT, 64'h8000_0000_0000_0000, 1, 0);
    run("div_7_m2", 0, 1, 64'd7, -64'sd2, DIV_LAT, -64'sd3, 0, 0);
    run("div_m7_m2", 0, 1, -64'sd7, -64'sd2, DIV_LAT, 64'd3, 0, 0);
    run("both_start", 1, 1, 64'd9, 64'd0, MUL_LAT, 64'd0, 0, 0);
    run("div_pulse_ignored", 1, 0, 64'd11, 64'd12, MUL_LAT, 64'd132, 0, 10);

    // Abort a divide with reset in cycle 30
    nrdy = 0;
    start_op(0, 1, 64'd1000, 64'd3);
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clock);
      if (data_resultRDY === 1'b1) nrdy++;
    end
    reset = 1'b1;
    @(negedge clock);
    check("abort.result", data_result, 64'd0);
    check("abort.exception", {63'd0, data_exception}, 64'd0);
    check("abort.rdy", {63'd0, data_resultRDY}, 64'd0);
    check("abort.busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) nrdy++;
    end
    check("abort.no_rdy", 64'(nrdy), 64'd0);
    run("mul_5_6", 1, 0, 64'd5, 64'd6, MUL_LAT, 64'd30, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
